// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle for imm_gen_pipe
//
// Input side:  in_valid, in_ready, inst, imm_sel, in_tag
// Output side: out_valid, out_ready, imm, out_sel, out_tag, fmt_err
// slave modport:  the pipeline's view (consumes inst, produces imm)
// master modport: the driver/consumer's view (the mirror image)
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       imm_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [2:0]       out_sel;
    logic [TAG_W-1:0] out_tag;
    logic             fmt_err;

    modport slave (
        input  in_valid, inst, imm_sel, in_tag, out_ready,
        output in_ready, out_valid, imm, out_sel, out_tag, fmt_err
    );

    modport master (
        output in_valid, inst, imm_sel, in_tag, out_ready,
        input  in_ready, out_valid, imm, out_sel, out_tag, fmt_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate generator with one output register and one skid register
//
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - imm_gen_pipe_if.slave (instruction in, immediate out, valid/ready both sides)
// Build option:
//   IMM_AUTO_DECODE_EN - derive the format from the opcode instead of imm_sel
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    imm_gen_pipe_if.slave   bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_I   = 3'd5;
    localparam logic [2:0] FMT_SH  = 3'd6;
    localparam logic [2:0] FMT_BAD = 3'd7;

    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [XLEN-1:0] imm_new;
    logic [5:0]  shamt;

    assign inst = bus.inst;

`ifdef IMM_AUTO_DECODE_EN
    logic unused_sel;
    assign unused_sel = ^bus.imm_sel;

    always_comb begin
        fmt = FMT_BAD;
        case (inst[6:0])
            // funct3 001 (slli) and 101 (srli/srai) share inst[13:12] == 01
            7'b0010011: fmt = (inst[13:12] == 2'b01) ? FMT_SH : FMT_I;
            7'b0000011,
            7'b1100111,
            7'b1110011: fmt = FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111,
            7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            7'b0110011: fmt = FMT_R;
            default:    fmt = FMT_BAD;
        endcase
    end
`else
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];
    assign fmt = bus.imm_sel;
`endif

    // RV64 shift amounts are 6 bits; RV32 only uses 5 and ignores inst[25]
    assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

    always_comb begin
        imm_new = '0;
        case (fmt)
            FMT_I:  imm_new = {{(XLEN-12){inst[31]}}, inst[31:20]};
            FMT_S:  imm_new = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:  imm_new = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                               inst[11:8], 1'b0};
            FMT_U:  imm_new = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            FMT_J:  imm_new = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                               inst[30:21], 1'b0};
            FMT_SH: imm_new = {{(XLEN-6){1'b0}}, shamt};
            default: imm_new = '0;
        endcase
    end

    logic             out_valid;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_sel;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_sel;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    logic accept;
    logic out_free;

    // in_ready depends only on registered skid state, never on out_ready
    assign accept   = bus.in_valid && !skid_valid;
    assign out_free = !out_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_sel    <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_sel   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // Skid is older than anything upstream; it goes first.
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_sel    <= skid_sel;
                out_tag    <= skid_tag;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_imm   <= imm_new;
                out_sel   <= fmt;
                out_tag   <= bus.in_tag;
                out_err   <= (fmt == FMT_BAD);
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Output is stalled: park the new result in the skid slot.
            skid_valid <= 1'b1;
            skid_imm   <= imm_new;
            skid_sel   <= fmt;
            skid_tag   <= bus.in_tag;
            skid_err   <= (fmt == FMT_BAD);
        end
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = out_valid;
    assign bus.imm       = out_imm;
    assign bus.out_sel   = out_sel;
    assign bus.out_tag   = out_tag;
    assign bus.fmt_err   = out_valid && out_err;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64 side by side)
module tb_imm_gen_pipe;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    typedef struct {
        logic [31:0]   inst;
        logic [2:0]    fmt;
        logic [TW-1:0] tag;
    } item_t;

    item_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] inst, input logic [2:0] sel);
`ifdef IMM_AUTO_DECODE_EN
        logic [6:0] op;
        logic [2:0] f3;
        op = inst[6:0];
        f3 = inst[14:12];
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return 3'd6;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return 3'd5;
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h37 || op == 7'h17) return 3'd3;
        if (op == 7'h6F) return 3'd4;
        if (op == 7'h33) return 3'd0;
        return 3'd7;
`else
        if (inst == 32'hFFFF_FFFF) return sel;
        return sel;
`endif
    endfunction

    // Immediates as signed arithmetic sums of the instruction fields
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] fmt,
                                            input int xlen);
        longint v;
        logic [63:0] r;
        v = 0;
        case (fmt)
            3'd5: begin
                if (inst[31]) v = -2048;
                v = v + longint'(inst[30:20]);
            end
            3'd1: begin
                if (inst[31]) v = -2048;
                v = v + longint'(inst[30:25]) * 32 + longint'(inst[11:7]);
            end
            3'd2: begin
                if (inst[31]) v = -4096;
                v = v + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                      + longint'(inst[11:8]) * 2;
            end
            3'd3: begin
                if (inst[31]) v = -(longint'(1) <<< 31);
                v = v + longint'(inst[30:12]) * 4096;
            end
            3'd4: begin
                if (inst[31]) v = -(longint'(1) <<< 20);
                v = v + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                      + longint'(inst[30:21]) * 2;
            end
            3'd6: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: v = 0;
        endcase
        r = v;
        if (xlen == 32) r = {32'h0, r[31:0]};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                         input logic [TW-1:0] tag, input logic ordy);
        b32.in_valid = v;  b64.in_valid = v;
        b32.inst = inst;   b64.inst = inst;
        b32.imm_sel = sel; b64.imm_sel = sel;
        b32.in_tag = tag;  b64.in_tag = tag;
        b32.out_ready = ordy; b64.out_ready = ordy;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_valid32"}, b32.out_valid, 0);
        check({pfx, "_ready32"}, b32.in_ready, 1);
        check({pfx, "_err32"},   b32.fmt_err, 0);
        check({pfx, "_imm32"},   b32.imm, 0);
        check({pfx, "_sel32"},   b32.out_sel, 0);
        check({pfx, "_tag32"},   b32.out_tag, 0);
        check({pfx, "_valid64"}, b64.out_valid, 0);
        check({pfx, "_ready64"}, b64.in_ready, 1);
        check({pfx, "_imm64"},   b64.imm, 0);
        check({pfx, "_err64"},   b64.fmt_err, 0);
    endtask

    task automatic check_outputs();
        item_t h;
        check("valid32", b32.out_valid, q.size() > 0);
        check("ready32", b32.in_ready, q.size() < 2);
        check("valid64", b64.out_valid, q.size() > 0);
        check("ready64", b64.in_ready, q.size() < 2);
        if (q.size() > 0) begin
            h = q[0];
            check("imm32", b32.imm, ref_imm(h.inst, h.fmt, 32));
            check("imm64", b64.imm, ref_imm(h.inst, h.fmt, 64));
            check("sel32", b32.out_sel, h.fmt);
            check("sel64", b64.out_sel, h.fmt);
            check("tag32", b32.out_tag, h.tag);
            check("tag64", b64.out_tag, h.tag);
            check("err32", b32.fmt_err, h.fmt == 3'd7);
            check("err64", b64.fmt_err, h.fmt == 3'd7);
        end else begin
            check("err32_idle", b32.fmt_err, 0);
        end
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                         input logic [TW-1:0] tag, input logic ordy);
        item_t it;
        logic do_out;
        logic do_in;
        drive(v, inst, sel, tag, ordy);
        @(negedge clk);
        check_outputs();
        do_out = (q.size() > 0) && ordy;
        do_in  = v && (q.size() < 2);
        if (do_out) void'(q.pop_front());
        if (do_in) begin
            it.inst = inst;
            it.fmt  = ref_fmt(inst, sel);
            it.tag  = tag;
            q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [12];
    initial begin
        logic [31:0] ri;
        logic        stall;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
                7'h13, 7'h7F};
        drive(0, 32'h0, 3'd0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        // known-answer instructions, one per cycle with a free output
        cycle(1, 32'hFFF00093, 3'd5, 5'd1, 1);
        cycle(1, 32'hFE000EE3, 3'd2, 5'd2, 1);
        cycle(1, 32'h0080006F, 3'd4, 5'd3, 1);
        cycle(1, 32'h800000B7, 3'd3, 5'd4, 1);
        cycle(1, 32'h03F09093, 3'd6, 5'd5, 1);
        cycle(1, 32'h00509093, 3'd0, 5'd6, 1);
        cycle(1, 32'h12345678, 3'd7, 5'd7, 1);
        cycle(0, 32'h0, 3'd0, 5'd0, 1);
        cycle(0, 32'h0, 3'd0, 5'd0, 1);

        // tags 1,2,3 back to back against a three-cycle stall
        cycle(1, 32'h00100093, 3'd5, 5'd1, 0);
        cycle(1, 32'h00200093, 3'd5, 5'd2, 0);
        cycle(1, 32'h00300093, 3'd5, 5'd3, 0);
        cycle(1, 32'h00300093, 3'd5, 5'd3, 1);
        cycle(1, 32'h00300093, 3'd5, 5'd3, 1);
        cycle(0, 32'h0, 3'd0, 5'd0, 1);
        cycle(0, 32'h0, 3'd0, 5'd0, 1);

        // fill output and skid, then reset between edges
        cycle(1, 32'hFFF00093, 3'd5, 5'd9, 0);
        cycle(1, 32'h800000B7, 3'd3, 5'd10, 0);
        cycle(1, 32'h0080006F, 3'd4, 5'd11, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 32'h0, 3'd0, 5'd0, 1);
        cycle(1, 32'h00509093, 3'd6, 5'd12, 1);
        cycle(0, 32'h0, 3'd0, 5'd0, 1);

        // randomized traffic with bursty back-pressure
        stall = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            ri = $urandom;
            if ($urandom_range(0, 3) != 0) ri[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 4) == 0) stall = ~stall;
            cycle($urandom_range(0, 9) < 7, ri, 3'($urandom_range(0, 7)),
                  TW'($urandom), stall ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0));
        end
        for (int n = 0; n < 4; n++) cycle(0, 32'h0, 3'd0, 5'd0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
